memory_stage: RTL and testbench
===============================

# memory_stage

Memory (M) pipeline stage of the NaiveMIPS core. It latches the execute-stage outputs (E_*), issues loads and stores on the SRAM-like data bus, and holds the pipeline with `dm_stall` while a transaction is outstanding. It extracts and sign- or zero-extends load data and drives the M_* forwarding and writeback bundle that the execute stage consumes.

## Interface
- Parameters: none.
- `Clk` in 1: clock.
- `Clr` in 1: reset, synchronous, active-high.
- `exp_flush` in 1: exception/eret flush; squashes the M instruction.
- `E_PC`, `E_EPC` in 32: PC and EPC of the incoming instruction.
- `E_Data` in 32: ALU result; this is the memory address for loads and stores.
- `E_WriteMemData` in 32: rt value; store data, and merge source for lwl/lwr.
- `E_MemWriteEnable` in 4: store byte strobes, already lane-shifted; 0 means not a store.
- `E_ExtType` in 9: one-hot load type. Bits: 0 lw, 1 lh, 2 lhu, 3 lb, 4 lbu, 5 lwl, 6 lwr, 7 ll, 8 mfc0-pass. All zero means not a load.
- `E_MemFamily` in 1: instruction accesses memory.
- `E_T`, `E_WriteRegEnable`, `E_RegId` in 4/1/5: forwarding tag, write enable, destination register.
- `E_OverFlow`, `E_data_alignment_err`, `E_inst_miss`, `E_inst_illegal`, `E_inst_invalid`, `E_in_delayslot` in 1 each: exception flags.
- `data_sram_req`, `data_sram_wr` out 1.
- `data_sram_size` out 2: 0 byte, 1 half, 2 word.
- `data_sram_addr`, `data_sram_wdata` out 32.
- `data_sram_wstrb` out 4.
- `data_sram_addr_ok`, `data_sram_data_ok` in 1.
- `data_sram_rdata` in 32.
- `dm_stall` out 1: freeze E and all earlier stages.
- `M_PC`, `M_EPC` out 32.
- `M_T` out 4, `M_WriteRegEnable` out 1, `M_RegId` out 5, `M_Data` out 32.
- `M_exc` out 1: OR of the latched exception flags.
- `M_in_delayslot` out 1.
- `M_BadVAddr` out 32: the latched address.

## Operation
- Stage register loads all E_* inputs on every edge where `dm_stall`=0.
  - `M_T` is loaded with `E_T`-1, saturating at 0.
- Issue condition: the latched instruction has `E_MemFamily`=1 and `M_exc`=0. When the latched instruction meets this condition, the FSM enters REQ. Instructions with an exception never reach the bus.
- FSM states and transitions:
  - IDLE: no transaction in progress.
  - REQ: `data_sram_req`=1 and the bus outputs are held stable. On `addr_ok`, go to WAIT.
  - WAIT: on `data_ok`, go to IDLE. For a load, `M_Data` is loaded with the extracted data on that same edge.
  - DRAIN: `req`=0; on `data_ok`, go to IDLE and discard the response.
- Bus fields:
  - `addr` = `{M_BadVAddr[31:2],2'b00}` for lwl/lwr, otherwise the full address.
  - `size` comes from the ExtType/strobe popcount; lwl/lwr use word size.
  - `wr` = |`wstrb`.
  - `wdata` = the store data already lane-aligned by the execute stage.
- `dm_stall` = (state != IDLE) | (issue condition is true while state==IDLE).
- Load data extraction uses address bits [1:0], little-endian:
  - lb/lh sign-extend; lbu/lhu zero-extend.
  - lw/ll pass the word through.
  - lwl/lwr merge the memory bytes with `E_WriteMemData`.
- While a load is pending (state != IDLE), the `M_T` output is forced to 1, so execute does not forward stale `M_Data`.
- Flush behaviour:
  - `exp_flush` clears the stage register: `M_WriteRegEnable`=0, `M_T`=0, `M_exc`=0.
  - From REQ with no `addr_ok` that cycle: drop `req` and go to IDLE.
  - From REQ with `addr_ok` that same cycle, or from WAIT: go to DRAIN.
  - A flush coinciding with `data_ok` goes to IDLE.
- Reset values (all outputs 0 unless listed):
  - `Clr` forces state IDLE from any state, including WAIT and DRAIN; the bus is reset in the same cycle.
  - All stage outputs are 0 and `dm_stall`=0.

## Timing
- A load with `addr_ok` and `data_ok` both returning in the cycle after request occupies M for 3 cycles: latch, REQ, WAIT. `M_Data` is valid, with `M_T`=0, on the cycle after `data_ok`.
- A store completes the same way. It writes no register, but it still waits for `data_ok`.
- Non-memory instructions: 1 cycle in M, `dm_stall`=0.
- `addr_ok` and `data_ok` may both assert in the same cycle. REQ with both high goes directly to IDLE and captures data on that edge.
- `data_ok` is never expected in REQ from an earlier request, because only one transaction is outstanding at a time.

## Configuration
- `MEM_UNALIGNED_LR_EN` defined: lwl/lwr perform the byte merge described above.
- `MEM_UNALIGNED_LR_EN` undefined: ExtType bits 5 and 6 are treated as lw, with the raw aligned word written back. The merge logic is removed.

## Structure
- Shared package `mem_pkg` holds:
  - the FSM state enum (IDLE, REQ, WAIT, DRAIN);
  - the ExtType bit-index constants;
  - the `data_sram_size` encodings.
- One sub-module, `load_extract`: purely combinational; inputs are rdata, offset, ExtType and rt; output is the write-back word.

## Test plan
- Load byte: lb at address 0x1003, rdata=0x80FF_1234 → `M_Data`=0xFFFF_FF80, `M_T`=0 on the cycle after `data_ok`.
- Store word: sw, `addr_ok` delayed 3 cycles → `req` stays high with a stable `addr`/`wdata`/`wstrb`=0xF; `dm_stall` is high until the cycle after `data_ok`.
- Flush in WAIT → DRAIN; `req`=0; the next load is not issued until the stale `data_ok` arrives; the stale rdata 0xDEADBEEF never reaches `M_Data`.
- Exception instruction: lw with `E_data_alignment_err`=1 → no `req`, `M_exc`=1, `dm_stall`=0.
- lwl with rt=0x11223344, rdata=0xAABBCCDD, offset 1 → `M_Data`=0xCCDD3344 when the macro is defined; 0xAABBCCDD when it is undefined.
- `Clr` asserted in WAIT → next cycle: state IDLE, all outputs 0, `dm_stall`=0.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared FSM state, ExtType bit indices and bus size codes
// for the memory stage.
package mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DRAIN
  } mstate_e;

  localparam int EXT_LW   = 0;
  localparam int EXT_LH   = 1;
  localparam int EXT_LHU  = 2;
  localparam int EXT_LB   = 3;
  localparam int EXT_LBU  = 4;
  localparam int EXT_LWL  = 5;
  localparam int EXT_LWR  = 6;
  localparam int EXT_LL   = 7;
  localparam int EXT_MFC0 = 8;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Loads size by type; stores by strobe popcount.
  function automatic logic [1:0] bus_size(
    input logic [8:0] ext,
    input logic [3:0] strb
  );
    logic [1:0] sz;
    if (ext[EXT_LB] | ext[EXT_LBU])
      sz = SZ_BYTE;
    else if (ext[EXT_LH] | ext[EXT_LHU])
      sz = SZ_HALF;
    else if (|ext[7:0])
      sz = SZ_WORD;
    else if ($countones(strb) == 1)
      sz = SZ_BYTE;
    else if ($countones(strb) == 2)
      sz = SZ_HALF;
    else
      sz = SZ_WORD;
    return sz;
  endfunction

endpackage

// File: rtl/memory_stage_load_extract.sv
// load_extract: aligns and extends load data for write-back.
// lwl/lwr byte merge present only with MEM_UNALIGNED_LR_EN.
module load_extract
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [8:0]  ext_type,
  input  logic [31:0] rt,
  output logic [31:0] wb
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

`ifdef MEM_UNALIGNED_LR_EN
  logic [4:0]  lwl_sh;
  logic [4:0]  lwr_sh;
  logic [31:0] lwl_v;
  logic [31:0] lwr_v;

  // lwl keeps rt's low bytes, lwr keeps rt's high bytes
  assign lwl_sh = {~offset, 3'b000};
  assign lwr_sh = {offset, 3'b000};
  assign lwl_v  = (rdata << lwl_sh)
                | (rt & ~(32'hFFFF_FFFF << lwl_sh));
  assign lwr_v  = (rdata >> lwr_sh)
                | (rt & ~(32'hFFFF_FFFF >> lwr_sh));
`else
  logic unused_rt;
  assign unused_rt = ^rt;
`endif

  assign byte_v = rdata[{offset, 3'b000} +: 8];
  assign half_v = rdata[{offset[1], 4'b0000} +: 16];

  always_comb begin
    wb = rdata;
    unique case (1'b1)
      ext_type[EXT_LB]:  wb = {{24{byte_v[7]}}, byte_v};
      ext_type[EXT_LBU]: wb = {24'd0, byte_v};
      ext_type[EXT_LH]:  wb = {{16{half_v[15]}}, half_v};
      ext_type[EXT_LHU]: wb = {16'd0, half_v};
`ifdef MEM_UNALIGNED_LR_EN
      ext_type[EXT_LWL]: wb = lwl_v;
      ext_type[EXT_LWR]: wb = lwr_v;
`else
      ext_type[EXT_LWL],
      ext_type[EXT_LWR]: wb = rdata;
`endif
      ext_type[EXT_LW],
      ext_type[EXT_LL],
      ext_type[EXT_MFC0]: wb = rdata;
      default: wb = rdata;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// memory_stage: M stage register, data-bus FSM and load write-back.
// Define MEM_UNALIGNED_LR_EN to enable the lwl/lwr byte merge.
module memory_stage
  import mem_pkg::*;
(
  input  logic        Clk,
  input  logic        Clr,
  input  logic        exp_flush,
  input  logic [31:0] E_PC,
  input  logic [31:0] E_EPC,
  input  logic [31:0] E_Data,
  input  logic [31:0] E_WriteMemData,
  input  logic [3:0]  E_MemWriteEnable,
  input  logic [8:0]  E_ExtType,
  input  logic        E_MemFamily,
  input  logic [3:0]  E_T,
  input  logic        E_WriteRegEnable,
  input  logic [4:0]  E_RegId,
  input  logic        E_OverFlow,
  input  logic        E_data_alignment_err,
  input  logic        E_inst_miss,
  input  logic        E_inst_illegal,
  input  logic        E_inst_invalid,
  input  logic        E_in_delayslot,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [1:0]  data_sram_size,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  output logic [3:0]  data_sram_wstrb,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  output logic        dm_stall,
  output logic [31:0] M_PC,
  output logic [31:0] M_EPC,
  output logic [3:0]  M_T,
  output logic        M_WriteRegEnable,
  output logic [4:0]  M_RegId,
  output logic [31:0] M_Data,
  output logic        M_exc,
  output logic        M_in_delayslot,
  output logic [31:0] M_BadVAddr
);

  mstate_e     state_q;
  logic [31:0] pc_q, epc_q, data_q, addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  strb_q;
  logic [8:0]  ext_q;
  logic [3:0]  t_q, t_d;
  logic        we_q, exc_q, ds_q, iss_q;
  logic [4:0]  rid_q;
  logic        exc_d;
  logic        is_load, is_lr, capture;
  logic        issue_idle;
  logic [31:0] ext_word;

  assign exc_d = E_OverFlow | E_data_alignment_err
               | E_inst_miss | E_inst_illegal
               | E_inst_invalid;
  assign t_d = (E_T == 4'd0) ? 4'd0 : E_T - 4'd1;

  assign is_load = |ext_q[7:0];
  assign is_lr   = ext_q[EXT_LWL] | ext_q[EXT_LWR];

  assign issue_idle = iss_q & (state_q == S_IDLE);
  assign dm_stall   = (state_q != S_IDLE) | issue_idle;

  assign capture = is_load & data_sram_data_ok
                 & ((state_q == S_WAIT)
                 | ((state_q == S_REQ) & data_sram_addr_ok));

  load_extract u_ext (
    .rdata    (data_sram_rdata),
    .offset   (addr_q[1:0]),
    .ext_type (ext_q),
    .rt       (wdata_q),
    .wb       (ext_word)
  );

  always_ff @(posedge Clk) begin
    if (Clr) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      epc_q   <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      ext_q   <= '0;
      t_q     <= '0;
      we_q    <= 1'b0;
      rid_q   <= '0;
      exc_q   <= 1'b0;
      ds_q    <= 1'b0;
      iss_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE:
          if (iss_q && !exp_flush) state_q <= S_REQ;
        S_REQ:
          if (data_sram_addr_ok) begin
            if (data_sram_data_ok) state_q <= S_IDLE;
            else if (exp_flush)    state_q <= S_DRAIN;
            else                   state_q <= S_WAIT;
          end else if (exp_flush) begin
            state_q <= S_IDLE;
          end
        S_WAIT:
          if (data_sram_data_ok) state_q <= S_IDLE;
          else if (exp_flush)    state_q <= S_DRAIN;
        S_DRAIN:
          if (data_sram_data_ok) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase

      if (exp_flush) begin
        pc_q    <= '0;
        epc_q   <= '0;
        data_q  <= '0;
        addr_q  <= '0;
        wdata_q <= '0;
        strb_q  <= '0;
        ext_q   <= '0;
        t_q     <= '0;
        we_q    <= 1'b0;
        rid_q   <= '0;
        exc_q   <= 1'b0;
        ds_q    <= 1'b0;
        iss_q   <= 1'b0;
      end else if (!dm_stall) begin
        pc_q    <= E_PC;
        epc_q   <= E_EPC;
        data_q  <= E_Data;
        addr_q  <= E_Data;
        wdata_q <= E_WriteMemData;
        strb_q  <= E_MemWriteEnable;
        ext_q   <= E_ExtType;
        t_q     <= t_d;
        we_q    <= E_WriteRegEnable;
        rid_q   <= E_RegId;
        exc_q   <= exc_d;
        ds_q    <= E_in_delayslot;
        iss_q   <= E_MemFamily & ~exc_d;
      end else begin
        // issue is one-shot per latched instruction
        if (state_q == S_IDLE) iss_q <= 1'b0;
        if (capture) data_q <= ext_word;
      end
    end
  end

  assign data_sram_req   = (state_q == S_REQ);
  assign data_sram_wstrb = data_sram_req ? strb_q : 4'd0;
  assign data_sram_wr    = |data_sram_wstrb;
  assign data_sram_wdata = data_sram_req ? wdata_q : 32'd0;
  assign data_sram_size  = data_sram_req ?
                           bus_size(ext_q, strb_q) : SZ_BYTE;
  assign data_sram_addr  = !data_sram_req ? 32'd0 :
                           is_lr ? {addr_q[31:2], 2'b00} :
                           addr_q;

  assign M_PC              = pc_q;
  assign M_EPC             = epc_q;
  assign M_T               = (is_load & dm_stall) ? 4'd1 : t_q;
  assign M_WriteRegEnable  = we_q;
  assign M_RegId           = rid_q;
  assign M_Data            = data_q;
  assign M_exc             = exc_q;
  assign M_in_delayslot    = ds_q;
  assign M_BadVAddr        = addr_q;

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed scoreboard bench for memory_stage.
module tb_memory_stage;

  logic        Clk = 1'b0;
  logic        Clr, exp_flush;
  logic [31:0] E_PC, E_EPC, E_Data, E_WriteMemData;
  logic [3:0]  E_MemWriteEnable;
  logic [8:0]  E_ExtType;
  logic        E_MemFamily;
  logic [3:0]  E_T;
  logic        E_WriteRegEnable;
  logic [4:0]  E_RegId;
  logic        E_OverFlow, E_data_alignment_err, E_inst_miss;
  logic        E_inst_illegal, E_inst_invalid, E_in_delayslot;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic [3:0]  data_sram_wstrb;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        dm_stall;
  logic [31:0] M_PC, M_EPC;
  logic [3:0]  M_T;
  logic        M_WriteRegEnable;
  logic [4:0]  M_RegId;
  logic [31:0] M_Data;
  logic        M_exc, M_in_delayslot;
  logic [31:0] M_BadVAddr;

  int vecs = 0;
  int errs = 0;
  logic [31:0] sb[$];
  logic [31:0] lwl_exp, lwr_exp;

  always #5 Clk = ~Clk;

  memory_stage dut (
    .Clk(Clk), .Clr(Clr), .exp_flush(exp_flush),
    .E_PC(E_PC), .E_EPC(E_EPC), .E_Data(E_Data),
    .E_WriteMemData(E_WriteMemData),
    .E_MemWriteEnable(E_MemWriteEnable),
    .E_ExtType(E_ExtType), .E_MemFamily(E_MemFamily),
    .E_T(E_T), .E_WriteRegEnable(E_WriteRegEnable),
    .E_RegId(E_RegId), .E_OverFlow(E_OverFlow),
    .E_data_alignment_err(E_data_alignment_err),
    .E_inst_miss(E_inst_miss),
    .E_inst_illegal(E_inst_illegal),
    .E_inst_invalid(E_inst_invalid),
    .E_in_delayslot(E_in_delayslot),
    .data_sram_req(data_sram_req),
    .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size),
    .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata),
    .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr_ok(data_sram_addr_ok),
    .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .dm_stall(dm_stall), .M_PC(M_PC), .M_EPC(M_EPC),
    .M_T(M_T), .M_WriteRegEnable(M_WriteRegEnable),
    .M_RegId(M_RegId), .M_Data(M_Data), .M_exc(M_exc),
    .M_in_delayslot(M_in_delayslot),
    .M_BadVAddr(M_BadVAddr)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_e();
    E_PC = 0; E_EPC = 0; E_Data = 0; E_WriteMemData = 0;
    E_MemWriteEnable = 0; E_ExtType = 0; E_MemFamily = 0;
    E_T = 0; E_WriteRegEnable = 0; E_RegId = 0;
    E_OverFlow = 0; E_data_alignment_err = 0;
    E_inst_miss = 0; E_inst_illegal = 0;
    E_inst_invalid = 0; E_in_delayslot = 0;
  endtask

  task automatic drive_load(input logic [31:0] a,
                            input logic [8:0] ext,
                            input logic [31:0] rt);
    clear_e();
    E_PC = 32'hBFC0_0100; E_Data = a; E_ExtType = ext;
    E_WriteMemData = rt; E_MemFamily = 1; E_T = 4'd1;
    E_WriteRegEnable = 1; E_RegId = 5'd7;
  endtask

  // From the latch cycle: REQ for dly+1 cycles, then WAIT.
  task automatic txn(input string tag, input int dly,
                     input logic both,
                     input logic [31:0] ea, input logic [1:0] esz,
                     input logic [3:0] es, input logic [31:0] ewd,
                     input logic [31:0] rd);
    step();
    for (int i = 0; i <= dly; i++) begin
      chk({tag, ".bus"},
          {data_sram_req, data_sram_wr, data_sram_size,
           data_sram_wstrb, data_sram_addr},
          {1'b1, |es, esz, es, ea});
      chk({tag, ".stall"}, dm_stall, 1);
      if (es != 0) chk({tag, ".wdata"}, data_sram_wdata, ewd);
      if (i == dly) begin
        data_sram_addr_ok = 1;
        if (both) begin
          data_sram_data_ok = 1;
          data_sram_rdata = rd;
        end
      end
      step();
    end
    data_sram_addr_ok = 0;
    if (!both) begin
      chk({tag, ".wait"}, {dm_stall, data_sram_req}, 2'b10);
      data_sram_data_ok = 1;
      data_sram_rdata = rd;
      step();
    end
    data_sram_data_ok = 0;
    data_sram_rdata = 0;
  endtask

  task automatic do_load(input string tag,
                         input logic [31:0] a,
                         input logic [8:0] ext,
                         input logic [31:0] rt,
                         input logic [31:0] rd,
                         input logic [1:0] esz,
                         input logic [31:0] expd,
                         input int dly, input logic both);
    logic [31:0] ba;
    ba = (ext[5] | ext[6]) ? {a[31:2], 2'b00} : a;
    drive_load(a, ext, rt);
    step();
    clear_e();
    chk({tag, ".lstall"}, dm_stall, 1);
    chk({tag, ".lmt"}, M_T, 4'd1);
    sb.push_back(expd);
    txn(tag, dly, both, ba, esz, 4'h0, 32'h0, rd);
    if (sb.size() == 0) chk({tag, ".sb"}, 0, 1);
    else chk({tag, ".data"}, M_Data, sb.pop_front());
    chk({tag, ".mt"}, M_T, 4'd0);
    chk({tag, ".done"}, {dm_stall, M_WriteRegEnable,
                         M_RegId}, {2'b01, 5'd7});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    clear_e();
    exp_flush = 0; data_sram_addr_ok = 0;
    data_sram_data_ok = 0; data_sram_rdata = 0;
    Clr = 1;
    step(); step();
    Clr = 0;
    chk("rst.stall", dm_stall, 0);
    chk("rst.req", data_sram_req, 0);
    chk("rst.out", {M_T, M_WriteRegEnable, M_exc, M_Data},
        {4'd0, 1'b0, 1'b0, 32'd0});

    // non-memory instruction; M_T decrements, saturates at 0
    E_Data = 32'h55; E_T = 4'd2; E_WriteRegEnable = 1;
    E_RegId = 5'd3; E_PC = 32'h100;
    step();
    chk("alu.out", {M_Data, M_T, M_RegId},
        {32'h55, 4'd1, 5'd3});
    chk("alu.stall", {dm_stall, data_sram_req}, 2'b00);
    E_T = 4'd0;
    step();
    chk("alu.tsat", M_T, 4'd0);
    clear_e();

    do_load("lb", 32'h1003, 9'h008, 0, 32'h80FF_1234,
            2'd0, 32'hFFFF_FF80, 0, 0);
    do_load("lh", 32'h2002, 9'h002, 0, 32'h9ABC_0000,
            2'd1, 32'hFFFF_9ABC, 1, 0);
    do_load("lhu", 32'h2000, 9'h004, 0, 32'h1234_F00D,
            2'd1, 32'h0000_F00D, 0, 1);
    do_load("lbu", 32'h2001, 9'h010, 0, 32'h0000_8000,
            2'd0, 32'h0000_0080, 0, 0);
    do_load("lw", 32'h2004, 9'h001, 0, 32'h0BAD_F00D,
            2'd2, 32'h0BAD_F00D, 0, 1);
`ifdef MEM_UNALIGNED_LR_EN
    lwl_exp = 32'hCCDD_3344;
    lwr_exp = 32'h1122_AABB;
`else
    lwl_exp = 32'hAABB_CCDD;
    lwr_exp = 32'hAABB_CCDD;
`endif
    do_load("lwl", 32'h3001, 9'h020, 32'h1122_3344,
            32'hAABB_CCDD, 2'd2, lwl_exp, 0, 0);
    do_load("lwr", 32'h3002, 9'h040, 32'h1122_3344,
            32'hAABB_CCDD, 2'd2, lwr_exp, 0, 0);

    // store word, addr_ok three cycles late
    clear_e();
    E_Data = 32'h4000; E_WriteMemData = 32'h1234_5678;
    E_MemWriteEnable = 4'hF; E_MemFamily = 1;
    step();
    clear_e();
    chk("sw.lstall", dm_stall, 1);
    txn("sw", 3, 0, 32'h4000, 2'd2, 4'hF,
        32'h1234_5678, 32'h0);
    chk("sw.done", {dm_stall, M_WriteRegEnable}, 2'b00);

    // exception instruction never reaches the bus
    drive_load(32'h5001, 9'h001, 0);
    E_data_alignment_err = 1;
    step();
    clear_e();
    chk("exc.m", {M_exc, dm_stall, data_sram_req}, 3'b100);
    step();
    chk("exc.req", {dm_stall, data_sram_req}, 2'b00);

    // flush in REQ without addr_ok: drop request
    drive_load(32'h6000, 9'h001, 0);
    step();
    clear_e();
    step();
    chk("fr.req", data_sram_req, 1);
    exp_flush = 1;
    step();
    exp_flush = 0;
    chk("fr.idle", {dm_stall, data_sram_req,
                    M_WriteRegEnable}, 3'b000);

    // flush in WAIT: drain stale response
    drive_load(32'h7000, 9'h001, 0);
    step();
    clear_e();
    step();
    data_sram_addr_ok = 1;
    step();
    data_sram_addr_ok = 0;
    exp_flush = 1;
    step();
    exp_flush = 0;
    drive_load(32'h7100, 9'h001, 0);
    chk("dr.st", {dm_stall, data_sram_req,
                  M_WriteRegEnable, M_T, M_exc},
        {3'b100, 4'd0, 1'b0});
    step();
    chk("dr.hold", {dm_stall, data_sram_req}, 2'b10);
    data_sram_data_ok = 1;
    data_sram_rdata = 32'hDEAD_BEEF;
    step();
    data_sram_data_ok = 0;
    data_sram_rdata = 0;
    chk("dr.stale", M_Data, 32'h0);
    chk("dr.idle", {dm_stall, data_sram_req}, 2'b00);
    do_load("dr.next", 32'h7100, 9'h001, 0,
            32'hCAFE_F00D, 2'd2, 32'hCAFE_F00D, 0, 0);

    // reset while in WAIT
    drive_load(32'h8000, 9'h001, 0);
    step();
    clear_e();
    step();
    data_sram_addr_ok = 1;
    step();
    data_sram_addr_ok = 0;
    chk("cw.wait", {dm_stall, data_sram_req}, 2'b10);
    Clr = 1;
    step();
    Clr = 0;
    chk("cw.bus", {dm_stall, data_sram_req, data_sram_addr},
        {2'b00, 32'h0});
    chk("cw.out", {M_PC, M_Data}, 64'h0);
    chk("cw.flags", {M_T, M_WriteRegEnable, M_exc, M_RegId},
        {4'd0, 2'b00, 5'd0});

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
